// File: rtl/demux1to2_stage_if.sv
// ----------------------------------------------------------------------------
// demux1to2_stage_if
// Stream bundle for the 1-to-2 demultiplexer stage: one producer-side channel
// (valid/ready/sel/data) and two consumer-side channels (valid/ready/data).
//
//   in_valid / in_ready / in_sel / in_data : producer beat, destination select
//   out0_valid / out0_ready / out0_data    : consumer 0 channel
//   out1_valid / out1_ready / out1_data    : consumer 1 channel
//
// Modports:
//   master : environment side (drives producer beat and consumer readies)
//   slave  : demux stage side
// ----------------------------------------------------------------------------
interface demux1to2_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux1to2_stage.sv
// ----------------------------------------------------------------------------
// demux1to2_stage
// Registered 1-to-2 stream demultiplexer. Each beat from the producer is
// steered to output 0 or 1 by its in_sel bit and lands in that channel's
// single register slot one cycle after acceptance.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset (slots emptied, data cleared)
//   flush        : synchronous clear of both slots; blocks acceptance that cycle
//   io (slave)   : producer channel and two consumer channels
//   cnt0, cnt1   : per-channel delivered-beat counters (DEMUX_STATS_EN only)
//
// Optional feature macro: DEMUX_STATS_EN adds the CNT_W parameter and the
// cnt0/cnt1 ports. Without it the stage is otherwise identical.
// ----------------------------------------------------------------------------
module demux1to2_stage #(
    parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
   ,parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    demux1to2_stage_if.slave  io
`ifdef DEMUX_STATS_EN
   ,output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t            st0_p1, st1_p1;
    slot_t            st0_nxt, st1_nxt;
    logic [WIDTH-1:0] data0_p1, data1_p1;
    logic             vld0_p1, vld1_p1;
    logic             sel_free, in_rdy;
    logic             acc0, acc1, drn0, drn1;

    // Handshake decode. in_ready looks only at the selected slot, so a stalled
    // beat for one channel blocks the producer even if the other slot is free;
    // this keeps beats in producer order.
    always_comb begin
        sel_free = io.in_sel ? (~vld1_p1 | io.out1_ready)
                             : (~vld0_p1 | io.out0_ready);
        in_rdy   = ~flush & sel_free;
        acc0     = io.in_valid & in_rdy & ~io.in_sel;
        acc1     = io.in_valid & in_rdy &  io.in_sel;
        drn0     = vld0_p1 & io.out0_ready;
        drn1     = vld1_p1 & io.out1_ready;
    end

    // Slot state next-state: flush > accept (covers drain+fill) > drain > hold.
    always_comb begin
        st0_nxt = st0_p1;
        if (flush)     st0_nxt = EMPTY;
        else if (acc0) st0_nxt = FULL;
        else if (drn0) st0_nxt = EMPTY;

        st1_nxt = st1_p1;
        if (flush)     st1_nxt = EMPTY;
        else if (acc1) st1_nxt = FULL;
        else if (drn1) st1_nxt = EMPTY;
    end

    // ---- stage p1: slot registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0_p1 <= EMPTY;
            st1_p1 <= EMPTY;
        end else begin
            st0_p1 <= st0_nxt;
            st1_p1 <= st1_nxt;
        end
    end

    // Payload only loads on accept, so a held beat is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data0_p1 <= '0;
            data1_p1 <= '0;
        end else begin
            if (acc0) data0_p1 <= io.in_data;
            if (acc1) data1_p1 <= io.in_data;
        end
    end

    // Outputs come straight from the slot registers.
    always_comb begin
        vld0_p1 = (st0_p1 == FULL);
        vld1_p1 = (st1_p1 == FULL);
    end

    assign io.in_ready   = in_rdy;
    assign io.out0_valid = vld0_p1;
    assign io.out0_data  = data0_p1;
    assign io.out1_valid = vld1_p1;
    assign io.out1_data  = data1_p1;

`ifdef DEMUX_STATS_EN
    // Counts completed handshakes per channel; wraps naturally, reset only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (drn0) cnt0 <= cnt0 + CNT_W'(1);
            if (drn1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux1to2_stage.sv
// ----------------------------------------------------------------------------
// tb_demux1to2_stage
// Directed bench for demux1to2_stage. A queue-based reference (one queue of
// depth <= 1 per consumer) tracks which beats are buffered; a negedge process
// compares handshake, valids, payloads and counters every cycle. Directed
// sequences add literal expectations at key points.
// ----------------------------------------------------------------------------
module tb_demux1to2_stage;
    localparam int WIDTH = 32;
`ifdef DEMUX_STATS_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    demux1to2_stage_if #(.WIDTH(WIDTH)) dif ();

    demux1to2_stage #(
        .WIDTH(WIDTH)
`ifdef DEMUX_STATS_EN
       ,.CNT_W(CNT_W)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .io   (dif.slave)
`ifdef DEMUX_STATS_EN
       ,.cnt0 (cnt0),
        .cnt1 (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    int unsigned      mcnt0 = 0;
    int unsigned      mcnt1 = 0;

    function automatic logic model_ready();
        if (flush) return 1'b0;
        if (dif.in_sel) return (mq1.size() == 0) || dif.out1_ready;
        return (mq0.size() == 0) || dif.out0_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            mcnt0 = 0;
            mcnt1 = 0;
        end else begin
            logic acc, d0, d1;
            acc = dif.in_valid && model_ready();
            d0  = (mq0.size() != 0) && dif.out0_ready;
            d1  = (mq1.size() != 0) && dif.out1_ready;
            if (d0) mcnt0++;
            if (d1) mcnt1++;
            if (flush) begin
                mq0.delete();
                mq1.delete();
            end else begin
                if (d0) void'(mq0.pop_front());
                if (d1) void'(mq1.pop_front());
                if (acc) begin
                    if (dif.in_sel) mq1.push_back(dif.in_data);
                    else            mq0.push_back(dif.in_data);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cmp_in_ready", dif.in_ready, model_ready());
        chk("cmp_out0_valid", dif.out0_valid, mq0.size() != 0);
        chk("cmp_out1_valid", dif.out1_valid, mq1.size() != 0);
        if (mq0.size() != 0) chk("cmp_out0_data", dif.out0_data, mq0[0]);
        if (mq1.size() != 0) chk("cmp_out1_data", dif.out1_data, mq1[0]);
`ifdef DEMUX_STATS_EN
        chk("cmp_cnt0", cnt0, mcnt0 % (1 << CNT_W));
        chk("cmp_cnt1", cnt1, mcnt1 % (1 << CNT_W));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
        dif.in_valid = v;
        dif.in_sel   = s;
        dif.in_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, '0);
        dif.out0_ready = 1'b0;
        dif.out1_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out0_valid", dif.out0_valid, 1'b0);
        chk("rst_out0_data", dif.out0_data, 32'h0);
        chk("rst_out1_data", dif.out1_data, 32'h0);

        // 1: async reset with slot0 full
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, '0);
        chk("t1_loaded_valid", dif.out0_valid, 1'b1);
        chk("t1_loaded_data", dif.out0_data, 32'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_valid", dif.out0_valid, 1'b0);
        chk("t1_async_data", dif.out0_data, 32'h0);
        step();
        rst = 1'b0;
        dif.in_sel = 1'b0;
        #1 chk("t1_ready_sel0", dif.in_ready, 1'b1);
        dif.in_sel = 1'b1;
        #1 chk("t1_ready_sel1", dif.in_ready, 1'b1);
        step();

        // 2: latency 1, full throughput on out0
        dif.out0_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'hA5A5_0001 + i);
            step();
            chk("t2_out0_valid", dif.out0_valid, 1'b1);
            chk("t2_out0_data", dif.out0_data, 32'hA5A5_0001 + i);
            chk("t2_out1_valid", dif.out1_valid, 1'b0);
        end
        drive(1'b0, 1'b0, '0);
        step();
        chk("t2_drained", dif.out0_valid, 1'b0);

        // 3: backpressure on out1
        dif.out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h11);
        step();
        drive(1'b1, 1'b1, 32'h22);
        #1 chk("t3_blocked", dif.in_ready, 1'b0);
        step();
        chk("t3_held_data", dif.out1_data, 32'h11);
        dif.out1_ready = 1'b1;
        #1 chk("t3_ready_on_drain", dif.in_ready, 1'b1);
        step();
        drive(1'b0, 1'b0, '0);
        chk("t3_next_valid", dif.out1_valid, 1'b1);
        chk("t3_next_data", dif.out1_data, 32'h22);
        step();
        chk("t3_empty", dif.out1_valid, 1'b0);

        // 4: head-of-line blocking; 0x33 (sel=1) queued behind blocked sel=0 beat
        dif.out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h44);
        step();
        drive(1'b1, 1'b0, 32'h45);
        #1 chk("t4_hol_ready", dif.in_ready, 1'b0);
        step();
        step();
        chk("t4_slot1_empty", dif.out1_valid, 1'b0);
        chk("t4_slot0_held", dif.out0_data, 32'h44);
        dif.out0_ready = 1'b1;
        step();
        chk("t4_slot0_refill", dif.out0_data, 32'h45);
        drive(1'b1, 1'b1, 32'h33);
        step();
        drive(1'b0, 1'b0, '0);
        chk("t4_out1_valid", dif.out1_valid, 1'b1);
        chk("t4_out1_data", dif.out1_data, 32'h33);
        step();

        // 5: flush with both slots full
        dif.out0_ready = 1'b0;
        dif.out1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h55);
        step();
        drive(1'b1, 1'b1, 32'h66);
        step();
        chk("t5_full0", dif.out0_valid, 1'b1);
        chk("t5_full1", dif.out1_valid, 1'b1);
        drive(1'b1, 1'b0, 32'h77);
        dif.out0_ready = 1'b1;
        flush = 1'b1;
        #1 chk("t5_flush_ready", dif.in_ready, 1'b0);
        dif.out0_ready = 1'b0;
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, '0);
        chk("t5_empty0", dif.out0_valid, 1'b0);
        chk("t5_empty1", dif.out1_valid, 1'b0);
        step();
        chk("t5_not_taken", dif.out0_valid, 1'b0);

`ifdef DEMUX_STATS_EN
        // 6: counter wrap (CNT_W=4) and flush independence
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_cnt0", cnt0, 4'd0);
        dif.out0_ready = 1'b1;
        dif.out1_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 32'h100 + i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h200 + i);
            step();
        end
        drive(1'b0, 1'b0, '0);
        step();
        chk("t6_cnt0_wrap", cnt0, 4'd1);
        chk("t6_cnt1", cnt1, 4'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("t6_flush_cnt0", cnt0, 4'd1);
        chk("t6_flush_cnt1", cnt1, 4'd3);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
